// File: rtl/key_bounce_gen_pkg.sv
// Shared definitions for the key bounce generator.
// Holds the FSM state encoding, the default parameter values, the LFSR tap
// mask and the LFSR helper functions used by both the LFSR and the top.
package key_bounce_gen_pkg;

  localparam int         DEF_BOUNCE_CYCLES = 5;
  localparam int         DEF_GAP_CYCLES    = 8;
  localparam logic [3:0] DEF_LFSR_SEED     = 4'h9;

  // x^4 + x^3 + 1: feedback is q[3] ^ q[2], shifted in at bit 0
  localparam logic [3:0] LFSR_TAP_MASK     = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE           = 3'd0,
    S_PRESS_BOUNCE   = 3'd1,
    S_HOLD           = 3'd2,
    S_RELEASE_BOUNCE = 3'd3,
    S_GAP            = 3'd4
  } key_state_e;

  // Feedback bit of the Fibonacci LFSR (also the next value of bit 0)
  function automatic logic lfsr_fb(input logic [3:0] q);
    return ^(q & LFSR_TAP_MASK);
  endfunction

  // One LFSR step
  function automatic logic [3:0] lfsr_step(input logic [3:0] q);
    return {q[2:0], lfsr_fb(q)};
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/key_bounce_gen_if.sv
// Request/status bundle of the key bounce generator.
//   req, hold_len, abort : press request, hold length, early abort (to DUT)
//   ready, done          : idle indication, end-of-sequence pulse (from DUT)
//   press_count          : number of presses that reached HOLD (from DUT)
//   KEY                  : emulated active-low push-button line (from DUT)
interface key_bounce_gen_if;
  logic       req;
  logic [7:0] hold_len;
  logic       abort;
  logic       ready;
  logic       done;
  logic [7:0] press_count;
  logic       KEY;

  modport master (
    output req, hold_len, abort,
    input  ready, done, press_count, KEY
  );

  modport slave (
    input  req, hold_len, abort,
    output ready, done, press_count, KEY
  );
endinterface

// File: rtl/key_bounce_gen_lfsr4.sv
// 4-bit Fibonacci LFSR (x^4 + x^3 + 1) that advances only while enabled.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset, loads i_seed
//   i_en   : advance one step at this edge
//   i_seed : reset value, must be nonzero
//   o_lfsr : current LFSR value
module key_lfsr4
  import key_bounce_gen_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [3:0] i_seed,
  output logic [3:0] o_lfsr
);

  logic [3:0] r_lfsr;

  // LFSR state: reload seed on reset, step when enabled, hold otherwise
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= i_seed;
    end else if (i_en) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end else begin
      r_lfsr <= r_lfsr;
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/key_bounce_gen.sv
// Push-button emulator: on an accepted request it drives KEY through a
// bouncing press, a stable-low hold, a bouncing release and an idle-high gap.
//   CLK50 : 50 MHz system clock
//   RST   : synchronous active-high reset
//   bus   : request/status bundle (req, hold_len, abort -> ready, done,
//           press_count, KEY)
// All outputs are registered from the next-state values, so KEY in every
// cycle reflects the state occupied in that same cycle.
module key_bounce_gen
  import key_bounce_gen_pkg::*;
#(
  parameter int         BOUNCE_CYCLES = DEF_BOUNCE_CYCLES,
  parameter int         GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter logic [3:0] LFSR_SEED     = DEF_LFSR_SEED
)
(
  input  logic               CLK50,
  input  logic               RST,
  key_bounce_gen_if.slave    bus
);

  localparam logic [2:0] ST_IDLE           = S_IDLE;
  localparam logic [2:0] ST_PRESS_BOUNCE   = S_PRESS_BOUNCE;
  localparam logic [2:0] ST_HOLD           = S_HOLD;
  localparam logic [2:0] ST_RELEASE_BOUNCE = S_RELEASE_BOUNCE;
  localparam logic [2:0] ST_GAP            = S_GAP;

  localparam int CNT_MAX = max3(BOUNCE_CYCLES, GAP_CYCLES, 255);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // The counter is loaded with (length - 1) on entry and leaves at zero
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_hold_len;
  logic             r_key;
  logic             r_ready;
  logic             r_done;
  logic [7:0]       r_press_count;

  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_hold_load;
  logic [3:0]       w_lfsr;
  logic             w_lfsr_en;
  logic             w_lfsr_bit_nxt;
  logic             w_accept;
  logic             w_key_nxt;
  logic             w_hold_entry;

  key_lfsr4 u_lfsr (
    .i_clk  (CLK50),
    .i_rst  (RST),
    .i_en   (w_lfsr_en),
    .i_seed (LFSR_SEED),
    .o_lfsr (w_lfsr)
  );

  assign w_accept     = (r_state == ST_IDLE) && bus.req;
  assign w_hold_load  = CNT_W'(r_hold_len - 8'd1);
  assign w_hold_entry = (w_state_nxt == ST_HOLD) && (r_state != ST_HOLD);

  // LFSR advances only at the end of cycles spent in a bounce state
  always_comb begin
    w_lfsr_en = (r_state == ST_PRESS_BOUNCE) || (r_state == ST_RELEASE_BOUNCE);
    if (w_lfsr_en) begin
      w_lfsr_bit_nxt = lfsr_fb(w_lfsr);
    end else begin
      w_lfsr_bit_nxt = w_lfsr[0];
    end
  end

  // Next state and counter; abort only matters in the three active press states
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_PRESS_BOUNCE;
          w_cnt_nxt   = BOUNCE_LOAD;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      ST_PRESS_BOUNCE: begin
        if (bus.abort) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = GAP_LOAD;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = w_hold_load;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (bus.abort) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = GAP_LOAD;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_RELEASE_BOUNCE;
          w_cnt_nxt   = BOUNCE_LOAD;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_ONE;
        end
      end
      ST_RELEASE_BOUNCE: begin
        if (bus.abort) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = GAP_LOAD;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_GAP;
          w_cnt_nxt   = GAP_LOAD;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // KEY for the coming cycle; the last bounce cycle is pinned to the settled level
  always_comb begin
    case (w_state_nxt)
      ST_PRESS_BOUNCE: begin
        if (w_cnt_nxt == '0) begin
          w_key_nxt = 1'b0;
        end else begin
          w_key_nxt = w_lfsr_bit_nxt;
        end
      end
      ST_HOLD: begin
        w_key_nxt = 1'b0;
      end
      ST_RELEASE_BOUNCE: begin
        if (w_cnt_nxt == '0) begin
          w_key_nxt = 1'b1;
        end else begin
          w_key_nxt = w_lfsr_bit_nxt;
        end
      end
      default: begin
        w_key_nxt = 1'b1;
      end
    endcase
  end

  // State, timer, latched hold length and registered outputs
  always_ff @(posedge CLK50) begin
    if (RST) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_hold_len    <= 8'd1;
      r_key         <= 1'b1;
      r_ready       <= 1'b1;
      r_done        <= 1'b0;
      r_press_count <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_key   <= w_key_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
      r_done  <= (w_state_nxt == ST_GAP) && (w_cnt_nxt == '0);
      if (w_accept) begin
        // A zero hold length still gives one HOLD cycle
        r_hold_len <= (bus.hold_len == 8'd0) ? 8'd1 : bus.hold_len;
      end else begin
        r_hold_len <= r_hold_len;
      end
      if (w_hold_entry) begin
        r_press_count <= r_press_count + 8'd1;
      end else begin
        r_press_count <= r_press_count;
      end
    end
  end

  assign bus.KEY         = r_key;
  assign bus.ready       = r_ready;
  assign bus.done        = r_done;
  assign bus.press_count = r_press_count;

endmodule

// File: tb/tb_key_bounce_gen.sv
// Directed, table-driven bench for key_bounce_gen with default parameters.
module tb_key_bounce_gen;

  logic CLK50 = 1'b0;
  logic RST;

  key_bounce_gen_if u_if ();

  key_bounce_gen #(
    .BOUNCE_CYCLES (5),
    .GAP_CYCLES    (8),
    .LFSR_SEED     (4'h9)
  ) dut (
    .CLK50 (CLK50),
    .RST   (RST),
    .bus   (u_if)
  );

  always #10 CLK50 = ~CLK50;

  int checks = 0;
  int errors = 0;

  // One sequence started from reset: KEY bit for cycle c is keys[32-c]
  typedef struct {
    logic [7:0]  hold;
    int          abort_at;
    int          done_at;
    logic [31:0] keys;
    logic [7:0]  pc;
  } vec_t;

  vec_t vecs [5];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK50);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    u_if.req = 1'b0;
    u_if.abort = 1'b0;
    step();
    RST = 1'b0;
  endtask

  logic [20:0] pat [3];
  int n_done;
  int cyc;

  initial begin
    // hold, abort cycle, done cycle, KEY trace (cycle 1 at MSB), press_count
    vecs[0] = '{8'd3,  0, 21, 32'b11010_000_11111_11111111_00000000000,   8'd1};
    vecs[1] = '{8'd0,  0, 19, 32'b11010_0_11111_11111111_0000000000000,   8'd1};
    vecs[2] = '{8'd10, 7, 15, 32'b11010_00_11111111_00000000000000000,    8'd1};
    vecs[3] = '{8'd3,  2, 10, 32'b11_11111111_0000000000000000000000,     8'd0};
    vecs[4] = '{8'd1,  9, 17, 32'b11010_0_111_11111111_000000000000000,   8'd1};

    // Back-to-back presses with hold 3 from the seed: LFSR keeps running
    pat[0] = 21'b11010_000_11111_11111111;
    pat[1] = 21'b00100_000_11011_11111111;
    pat[2] = 21'b11110_000_00101_11111111;

    // Reset with req and abort high: reset wins
    RST = 1'b1;
    u_if.req = 1'b1;
    u_if.abort = 1'b1;
    u_if.hold_len = 8'd0;
    step();
    check1("rst key", u_if.KEY, 1'b1);
    check1("rst ready", u_if.ready, 1'b1);
    check1("rst done", u_if.done, 1'b0);
    check8("rst count", u_if.press_count, 8'd0);
    RST = 1'b0;
    u_if.req = 1'b0;
    u_if.abort = 1'b0;
    step();
    check1("rst no accept", u_if.ready, 1'b1);

    // Table-driven single sequences
    for (int i = 0; i < 5; i++) begin
      do_reset();
      u_if.hold_len = vecs[i].hold;
      u_if.req = 1'b1;
      step();
      u_if.req = 1'b0;
      for (int c = 1; c <= vecs[i].done_at; c++) begin
        check1($sformatf("v%0d key c%0d", i, c), u_if.KEY, vecs[i].keys[32-c]);
        check1($sformatf("v%0d done c%0d", i, c), u_if.done, (c == vecs[i].done_at));
        check1($sformatf("v%0d ready c%0d", i, c), u_if.ready, 1'b0);
        u_if.abort = (c == vecs[i].abort_at);
        step();
      end
      u_if.abort = 1'b0;
      check1($sformatf("v%0d idle ready", i), u_if.ready, 1'b1);
      check1($sformatf("v%0d idle key", i), u_if.KEY, 1'b1);
      check1($sformatf("v%0d idle done", i), u_if.done, 1'b0);
      check8($sformatf("v%0d count", i), u_if.press_count, vecs[i].pc);
    end

    // req held high: three back-to-back sequences, one IDLE cycle between
    do_reset();
    u_if.hold_len = 8'd3;
    u_if.req = 1'b1;
    step();
    for (int p = 0; p < 3; p++) begin
      for (int c = 1; c <= 21; c++) begin
        check1($sformatf("b2b p%0d key c%0d", p, c), u_if.KEY, pat[p][21-c]);
        check1($sformatf("b2b p%0d done c%0d", p, c), u_if.done, (c == 21));
        step();
      end
      check1($sformatf("b2b p%0d idle ready", p), u_if.ready, 1'b1);
      check1($sformatf("b2b p%0d idle key", p), u_if.KEY, 1'b1);
      step();
    end
    u_if.req = 1'b0;
    check1("b2b restarted", u_if.ready, 1'b0);
    check8("b2b count", u_if.press_count, 8'd3);

    // abort alone in IDLE ignored; req+abort in IDLE accepted; abort in GAP
    // ignored; req while busy not queued
    do_reset();
    u_if.abort = 1'b1;
    step();
    step();
    check1("idle abort ready", u_if.ready, 1'b1);
    check1("idle abort key", u_if.KEY, 1'b1);
    u_if.hold_len = 8'd3;
    u_if.req = 1'b1;
    step();
    u_if.req = 1'b0;
    u_if.abort = 1'b0;
    check1("req+abort accepted", u_if.ready, 1'b0);
    for (int c = 1; c <= 21; c++) begin
      check1($sformatf("gap abort done c%0d", c), u_if.done, (c == 21));
      u_if.req = (c >= 5) && (c <= 10);
      u_if.abort = (c >= 14) && (c <= 20);
      step();
    end
    u_if.req = 1'b0;
    u_if.abort = 1'b0;
    check1("after seq ready", u_if.ready, 1'b1);
    step();
    check1("no queued req", u_if.ready, 1'b1);
    check8("gap abort count", u_if.press_count, 8'd1);

    // Reset in the middle of HOLD
    do_reset();
    u_if.hold_len = 8'd10;
    u_if.req = 1'b1;
    step();
    u_if.req = 1'b0;
    for (int c = 1; c < 7; c++) begin
      step();
    end
    check1("mid hold key", u_if.KEY, 1'b0);
    check8("mid hold count", u_if.press_count, 8'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check1("rst hold key", u_if.KEY, 1'b1);
    check1("rst hold ready", u_if.ready, 1'b1);
    check1("rst hold done", u_if.done, 1'b0);
    check8("rst hold count", u_if.press_count, 8'd0);
    u_if.hold_len = 8'd3;
    u_if.req = 1'b1;
    step();
    u_if.req = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check1($sformatf("reseed key c%0d", c), u_if.KEY, pat[0][21-c]);
      step();
    end

    // 256 completed presses wrap press_count to zero
    do_reset();
    u_if.hold_len = 8'd0;
    u_if.req = 1'b1;
    n_done = 0;
    cyc = 0;
    while ((n_done < 256) && (cyc < 6000)) begin
      step();
      cyc++;
      if (u_if.done) begin
        n_done++;
        if (n_done == 255) begin
          check8("count 255", u_if.press_count, 8'd255);
        end else if (n_done == 256) begin
          check8("count wrap", u_if.press_count, 8'd0);
        end else begin
          n_done = n_done;
        end
      end else begin
        n_done = n_done;
      end
    end
    u_if.req = 1'b0;
    checki("presses completed", n_done, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_bounce_gen.md
KEY_BOUNCE_GEN -- requirements
Module: key_bounce_gen

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter BOUNCE_CYCLES, default 5: bounce cycles per edge, minimum 1.
REQ-003 Parameter GAP_CYCLES, default 8: idle-high cycles after release, minimum 1.
REQ-004 Parameter LFSR_SEED, default 4'h9: LFSR reset value, SHALL be nonzero.
REQ-005 Port CLK50, input, 1: 50 MHz system clock.
REQ-006 Port RST, input, 1: synchronous, active-high reset.
REQ-007 Port req, input, 1: press request, accepted only while ready=1.
REQ-008 Port hold_len, input, 8: stable-low cycles, sampled on acceptance.
REQ-009 Port abort, input, 1: cut the current press short.
REQ-010 Port ready, output, 1: high only in IDLE.
REQ-011 Port done, output, 1: one-cycle pulse at sequence end.
REQ-012 Port press_count, output, 8: count of presses that reached HOLD, wraps.
REQ-013 Port KEY, output, 1: emulated active-low push-button line, registered.

Function
REQ-014 The FSM SHALL have states IDLE, PRESS_BOUNCE, HOLD, RELEASE_BOUNCE, GAP.
REQ-015 The FSM SHALL treat an edge with ready=1 and req=1 as the acceptance edge E0; it SHALL latch hold_len (0 treated as 1) and enter PRESS_BOUNCE.
REQ-016 KEY SHALL be registered so that its value in each cycle after E0 matches the state occupied in that cycle; no extra latency.
REQ-017 In PRESS_BOUNCE (BOUNCE_CYCLES cycles), KEY SHALL equal lfsr[0]; the last cycle SHALL be forced to 0.
REQ-018 In HOLD (latched hold_len cycles), KEY SHALL be 0; press_count SHALL increment once on HOLD entry, 8'hFF wrapping to 8'h00.
REQ-019 In RELEASE_BOUNCE (BOUNCE_CYCLES cycles), KEY SHALL equal lfsr[0]; the last cycle SHALL be forced to 1.
REQ-020 In GAP (GAP_CYCLES cycles), KEY SHALL be 1; done SHALL be 1 in the final GAP cycle only; the next cycle SHALL be IDLE with ready=1.
REQ-021 The 4-bit LFSR, Fibonacci x^4+x^3+1, SHALL advance only on cycles spent in PRESS_BOUNCE or RELEASE_BOUNCE and hold otherwise.
REQ-022 One down-counter, wide enough for max(BOUNCE_CYCLES, GAP_CYCLES, 255), SHALL time every state; it SHALL reload on state entry.
REQ-023 On abort=1 in PRESS_BOUNCE, HOLD or RELEASE_BOUNCE, the next cycle SHALL enter GAP with KEY=1; abort SHALL be ignored in IDLE and GAP.
REQ-024 On req and abort together in IDLE, the request SHALL be accepted and abort ignored.
REQ-025 req SHALL be ignored while ready=0; no request is queued.
REQ-026 An abort before HOLD entry SHALL NOT increment press_count.

Reset
REQ-027 On RST, all state SHALL reset within one edge: state=IDLE, KEY=1, ready=1, done=0, press_count=0, lfsr=LFSR_SEED, counter=0.
REQ-028 RST SHALL override req and abort on the same edge; reset mid-sequence SHALL return KEY to 1 on the next cycle.

Structure
REQ-029 A shared package SHALL hold the state enum, default parameter constants, and the LFSR tap mask.
REQ-030 The LFSR SHALL be one sub-module, key_lfsr4 (enable, seed, 4-bit output); the remainder SHALL stay flat.

Verification
REQ-031 Defaults, hold_len=3, req pulse: KEY = 5 bounce cycles (5th=0), then 0,0,0, then 5 bounce cycles (5th=1), then 8 ones; done in cycle 21 after E0; press_count=1.
REQ-032 hold_len=0: exactly 1 HOLD cycle; done in cycle 19 after E0.
REQ-033 Abort in 2nd HOLD cycle with hold_len=10: KEY=1 from the next cycle; done 8 cycles later; press_count=1.
REQ-034 Abort in PRESS_BOUNCE cycle 2: GAP follows, done pulses, press_count unchanged.
REQ-035 req held high continuously: back-to-back sequences, with exactly one IDLE cycle (ready=1) between done and the next PRESS_BOUNCE.
REQ-036 RST mid-HOLD: next cycle KEY=1, ready=1, press_count=0; 256 completed presses give press_count=0.
